// File: rtl/mem_stage_sram_controller.sv
// ---------------------------------------------------------------------------
// mem_stage_sram_controller
//
// Memory-stage sequencer between the EXE->MEM pipeline register and an
// external 16-bit asynchronous SRAM. Each 32-bit load/store becomes two
// half-word accesses (low half first), each lasting ACCESS_CYCLES clocks.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   wr_en        store request (wins over rd_en when both are set)
//   rd_en        load request
//   address      byte address from the ALU, word aligned
//   write_data   store value
//   read_data    loaded word; valid in DONE, held until the next load completes
//   ready        1 = no access pending or access finishing this cycle
//   sram_addr    SRAM half-word address
//   sram_dq_out  SRAM write data
//   sram_dq_in   SRAM read data
//   sram_dq_oe   1 = drive sram_dq_out onto the SRAM data bus
//   sram_we_n    SRAM write enable, active low
//
// Handshake: a request (wr_en | rd_en) seen in IDLE is accepted at the next
// rising edge. ready stays low from the request cycle until DONE, where it
// rises for exactly one cycle; the pipeline holds its registers (freeze =
// ~ready), so the request is still visible during DONE and is deliberately
// ignored there. A request present in the following IDLE cycle is a new one.
// ---------------------------------------------------------------------------
module mem_stage_sram_controller #(
    parameter int BASE_ADDR     = 1024,
    parameter int ACCESS_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n
);

    localparam int          CW   = $clog2(ACCESS_CYCLES) + 1;
    localparam logic [31:0] BASE = 32'(BASE_ADDR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic            op_write;
    logic [16:0]     word_q;
    logic [31:0]     wdata_q;

    logic            req;
    logic            last_cycle;
    logic [31:0]     offset;
    logic            unused_addr_bits;

    assign req        = wr_en | rd_en;
    assign last_cycle = (count == CW'(ACCESS_CYCLES - 1));

    // Byte offset into data memory; addresses below BASE wrap naturally
    // because only the 17-bit word index is kept.
    assign offset           = address - BASE;
    assign unused_addr_bits = ^{offset[31:19], offset[1:0]};

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = LOW;
            LOW:     if (last_cycle) state_next = HIGH;
            HIGH:    if (last_cycle) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- request latch, wait counter, read capture ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            op_write  <= 1'b0;
            word_q    <= '0;
            wdata_q   <= '0;
            read_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    if (req) begin
                        op_write <= wr_en;
                        word_q   <= offset[18:2];
                        wdata_q  <= write_data;
                    end
                end
                LOW: begin
                    if (last_cycle) begin
                        count <= '0;
                        if (!op_write) read_data[15:0] <= sram_dq_in;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                HIGH: begin
                    if (last_cycle) begin
                        count <= '0;
                        if (!op_write) read_data[31:16] <= sram_dq_in;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: count <= '0;
            endcase
        end
    end

    // ---------------- outputs ----------------
    // SRAM pins are decoded from registered state and latched request data,
    // so they only move at state transitions.
    always_comb begin
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state)
            IDLE: ready = ~req;
            LOW: begin
                sram_addr = {word_q, 1'b0};
                if (op_write) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[15:0];
                end
            end
            HIGH: begin
                sram_addr = {word_q, 1'b1};
                if (op_write) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[31:16];
                end
            end
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mem_stage_sram_controller.sv
// ---------------------------------------------------------------------------
// Bench for mem_stage_sram_controller. Two instances: ACCESS_CYCLES=3 and
// ACCESS_CYCLES=1. A transaction-level reference model counts cycles from the
// accepted request and derives every output from that position, the latched
// request and its own copy of memory.
// ---------------------------------------------------------------------------
module tb_mem_stage_sram_controller;

    localparam int BASE = 1024;
    localparam int A0   = 3;
    localparam int A1   = 1;

    logic        clk;
    logic        rst;
    logic        wr_en       [2];
    logic        rd_en       [2];
    logic [31:0] address     [2];
    logic [31:0] write_data  [2];
    logic [31:0] read_data   [2];
    logic        ready       [2];
    logic [17:0] sram_addr   [2];
    logic [15:0] sram_dq_out [2];
    logic [15:0] sram_dq_in  [2];
    logic        sram_dq_oe  [2];
    logic        sram_we_n   [2];

    int checks   = 0;
    int failures = 0;
    int acc_of [2] = '{A0, A1};

    mem_stage_sram_controller #(.BASE_ADDR(BASE), .ACCESS_CYCLES(A0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en[0]), .rd_en(rd_en[0]),
        .address(address[0]), .write_data(write_data[0]), .read_data(read_data[0]),
        .ready(ready[0]), .sram_addr(sram_addr[0]), .sram_dq_out(sram_dq_out[0]),
        .sram_dq_in(sram_dq_in[0]), .sram_dq_oe(sram_dq_oe[0]), .sram_we_n(sram_we_n[0])
    );

    mem_stage_sram_controller #(.BASE_ADDR(BASE), .ACCESS_CYCLES(A1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en[1]), .rd_en(rd_en[1]),
        .address(address[1]), .write_data(write_data[1]), .read_data(read_data[1]),
        .ready(ready[1]), .sram_addr(sram_addr[1]), .sram_dq_out(sram_dq_out[1]),
        .sram_dq_in(sram_dq_in[1]), .sram_dq_oe(sram_dq_oe[1]), .sram_we_n(sram_we_n[1])
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memories: SRAM device and reference copy ----------------
    logic [15:0] env_mem0 [int];
    logic [15:0] env_mem1 [int];
    logic [15:0] ref_mem0 [int];
    logic [15:0] ref_mem1 [int];

    function automatic logic [15:0] env_rd(input int i, input int a);
        if (i == 0) return env_mem0.exists(a) ? env_mem0[a] : 16'h0;
        return env_mem1.exists(a) ? env_mem1[a] : 16'h0;
    endfunction

    function automatic logic [15:0] ref_rd(input int i, input int a);
        if (i == 0) return ref_mem0.exists(a) ? ref_mem0[a] : 16'h0;
        return ref_mem1.exists(a) ? ref_mem1[a] : 16'h0;
    endfunction

    task automatic env_wr(input int i, input int a, input logic [15:0] d);
        if (i == 0) env_mem0[a] = d;
        else        env_mem1[a] = d;
    endtask

    task automatic ref_wr(input int i, input int a, input logic [15:0] d);
        if (i == 0) ref_mem0[a] = d;
        else        ref_mem1[a] = d;
    endtask

    // Asynchronous SRAM device: writes while we_n is low, read data follows address.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!sram_we_n[i] && sram_dq_oe[i]) env_wr(i, int'(sram_addr[i]), sram_dq_out[i]);
            sram_dq_in[i] = env_rd(i, int'(sram_addr[i]));
        end
    end

    // ---------------- checker ----------------
    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d t=%0t got=%h expected=%h", nm, i, $time, got, exp);
        end
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    // k = cycles since the request was seen: 0 idle/request cycle,
    // 1..A low half, A+1..2A high half, 2A+1 completion cycle.
    int          k      [2] = '{0, 0};
    bit          m_wr   [2];
    logic [16:0] m_word [2];
    logic [31:0] m_wd   [2];
    logic [31:0] m_rd   [2] = '{32'h0, 32'h0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int a;
            int half;
            bit hi;
            a = acc_of[i];
            if (rst) begin
                k[i]    = 0;
                m_rd[i] = 32'h0;
            end else if (k[i] == 0) begin
                chk("idle_ready", i, ready[i], !(wr_en[i] || rd_en[i]));
                chk("idle_we_n", i, sram_we_n[i], 1'b1);
                chk("idle_oe", i, sram_dq_oe[i], 1'b0);
                chk("idle_rdata", i, read_data[i], m_rd[i]);
                if (wr_en[i] || rd_en[i]) begin
                    m_wr[i]   = wr_en[i];
                    m_word[i] = 17'((address[i] - 32'(BASE)) / 4);
                    m_wd[i]   = write_data[i];
                    if (m_wr[i]) begin
                        ref_wr(i, 2 * int'(m_word[i]),     m_wd[i][15:0]);
                        ref_wr(i, 2 * int'(m_word[i]) + 1, m_wd[i][31:16]);
                    end
                    k[i] = 1;
                end
            end else if (k[i] <= 2 * a) begin
                hi   = (k[i] > a);
                half = 2 * int'(m_word[i]) + (hi ? 1 : 0);
                chk("busy_ready", i, ready[i], 1'b0);
                chk("busy_addr", i, sram_addr[i], half);
                chk("busy_we_n", i, sram_we_n[i], !m_wr[i]);
                chk("busy_oe", i, sram_dq_oe[i], m_wr[i]);
                if (m_wr[i]) chk("busy_dq_out", i, sram_dq_out[i], hi ? m_wd[i][31:16] : m_wd[i][15:0]);
                chk("busy_rdata", i, read_data[i], m_rd[i]);
                if (!m_wr[i] && k[i] == a)     m_rd[i][15:0]  = ref_rd(i, half);
                if (!m_wr[i] && k[i] == 2 * a) m_rd[i][31:16] = ref_rd(i, half);
                k[i] = k[i] + 1;
            end else begin
                chk("done_ready", i, ready[i], 1'b1);
                chk("done_we_n", i, sram_we_n[i], 1'b1);
                chk("done_oe", i, sram_dq_oe[i], 1'b0);
                chk("done_rdata", i, read_data[i], m_rd[i]);
                k[i] = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic access(input int i, input bit wr, input bit rd, input logic [31:0] a,
                          input logic [31:0] wd, input bit scribble, output int lows,
                          output logic [17:0] lo_addr, output logic [15:0] lo_dq,
                          output logic [17:0] hi_addr, output logic [15:0] hi_dq,
                          output logic [31:0] rdata);
        bit done;
        @(posedge clk); #1;
        wr_en[i] = wr; rd_en[i] = rd; address[i] = a; write_data[i] = wd;
        lows = 0; lo_addr = '0; lo_dq = '0; hi_addr = '0; hi_dq = '0; done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ready[i]) begin
                done = 1'b1;
                break;
            end
            if (n == 1) begin
                lo_addr = sram_addr[i];
                lo_dq   = sram_dq_out[i];
            end
            if (n >= 1) begin
                hi_addr = sram_addr[i];
                hi_dq   = sram_dq_out[i];
            end
            lows++;
            if (scribble && n >= 1) begin
                address[i]    = $urandom;
                write_data[i] = $urandom;
            end
        end
        chk("ready_timeout", i, done, 1'b1);
        rdata = read_data[i];
    endtask

    task automatic go_idle(input int i, input int n);
        @(posedge clk); #1;
        wr_en[i] = 1'b0; rd_en[i] = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          lows;
        logic [17:0] la, ha;
        logic [15:0] ld, hd;
        logic [31:0] rd;
        int          op;
        logic [31:0] addr;
        logic [15:0] pv;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_en[i] = 1'b0; rd_en[i] = 1'b0; address[i] = '0; write_data[i] = '0;
        end

        // Reset values
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", i, ready[i], 1'b1);
            chk("rst_we_n", i, sram_we_n[i], 1'b1);
            chk("rst_oe", i, sram_dq_oe[i], 1'b0);
            chk("rst_rdata", i, read_data[i], 32'h0);
            chk("rst_addr", i, sram_addr[i], 18'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed, ACCESS_CYCLES=3
        access(0, 1, 0, 32'd1032, 32'hDEADBEEF, 0, lows, la, ld, ha, hd, rd);
        chk("wr_lows", 0, lows, 7);
        chk("wr_lo_addr", 0, la, 18'd4);
        chk("wr_lo_dq", 0, ld, 16'hBEEF);
        chk("wr_hi_addr", 0, ha, 18'd5);
        chk("wr_hi_dq", 0, hd, 16'hDEAD);
        go_idle(0, 1);
        access(0, 0, 1, 32'd1032, 32'h0, 0, lows, la, ld, ha, hd, rd);
        chk("rd_lows", 0, lows, 7);
        chk("rd_data", 0, rd, 32'hDEADBEEF);
        go_idle(0, 0);

        // Both enables set: write wins, read_data untouched
        access(0, 1, 1, 32'd1040, 32'h12345678, 0, lows, la, ld, ha, hd, rd);
        chk("both_rdata_kept", 0, rd, 32'hDEADBEEF);
        chk("both_lo_dq", 0, ld, 16'h5678);
        go_idle(0, 0);
        access(0, 0, 1, 32'd1040, 32'h0, 0, lows, la, ld, ha, hd, rd);
        chk("both_readback", 0, rd, 32'h12345678);

        // Back-to-back store then load, request held through DONE
        access(0, 1, 0, 32'd1048, 32'hCAFEF00D, 1, lows, la, ld, ha, hd, rd);
        chk("b2b_wr_lows", 0, lows, 7);
        access(0, 0, 1, 32'd1048, 32'h0, 1, lows, la, ld, ha, hd, rd);
        chk("b2b_rd_lows", 0, lows, 7);
        chk("b2b_rd_data", 0, rd, 32'hCAFEF00D);
        go_idle(0, 0);

        // Address below BASE wraps to the top of the word space
        access(0, 1, 0, 32'd1020, 32'hA5A55A5A, 0, lows, la, ld, ha, hd, rd);
        chk("wrap_lo_addr", 0, la, 18'h3FFFE);
        chk("wrap_hi_addr", 0, ha, 18'h3FFFF);
        go_idle(0, 0);
        access(0, 0, 1, 32'd1020, 32'h0, 0, lows, la, ld, ha, hd, rd);
        chk("wrap_readback", 0, rd, 32'hA5A55A5A);
        go_idle(0, 0);

        // Reset in the middle of the low half of a load
        @(posedge clk); #1;
        rd_en[0] = 1'b1; address[0] = 32'd1048;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1; rd_en[0] = 1'b0;
        #1;
        chk("arst_ready", 0, ready[0], 1'b1);
        chk("arst_we_n", 0, sram_we_n[0], 1'b1);
        chk("arst_oe", 0, sram_dq_oe[0], 1'b0);
        chk("arst_rdata", 0, read_data[0], 32'h0);
        chk("arst_addr", 0, sram_addr[0], 18'h0);
        @(negedge clk);
        chk("arst_ready_smp", 0, ready[0], 1'b1);
        chk("arst_rdata_smp", 0, read_data[0], 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        access(0, 0, 1, 32'd1032, 32'h0, 0, lows, la, ld, ha, hd, rd);
        chk("post_rst_read", 0, rd, 32'hDEADBEEF);
        go_idle(0, 0);

        // Directed, ACCESS_CYCLES=1
        access(1, 1, 0, 32'd1032, 32'h01234567, 0, lows, la, ld, ha, hd, rd);
        chk("a1_wr_lows", 1, lows, 3);
        chk("a1_lo_addr", 1, la, 18'd4);
        chk("a1_lo_dq", 1, ld, 16'h4567);
        chk("a1_hi_addr", 1, ha, 18'd5);
        chk("a1_hi_dq", 1, hd, 16'h0123);
        access(1, 0, 1, 32'd1032, 32'h0, 0, lows, la, ld, ha, hd, rd);
        chk("a1_rd_lows", 1, lows, 3);
        chk("a1_rd_data", 1, rd, 32'h01234567);
        go_idle(1, 0);

        // Preload identical random contents into device and reference
        for (int i = 0; i < 2; i++) begin
            for (int h = 0; h < 32; h++) begin
                pv = 16'($urandom);
                env_wr(i, h, pv);
                ref_wr(i, h, pv);
            end
        end

        // Randomized traffic
        for (int i = 0; i < 2; i++) begin
            for (int t = 0; t < 40; t++) begin
                op = $urandom_range(0, 2);
                if ($urandom_range(0, 7) == 0) addr = 32'(BASE) - 32'(4 * $urandom_range(1, 4));
                else                           addr = 32'(BASE) + 32'(4 * $urandom_range(0, 15));
                access(i, op != 0, op != 1, addr, $urandom, 1'($urandom_range(0, 1)),
                       lows, la, ld, ha, hd, rd);
                chk("rnd_lows", i, lows, 2 * acc_of[i] + 1);
                if ($urandom_range(0, 1) == 1) go_idle(i, $urandom_range(0, 2));
            end
            go_idle(i, 1);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout t=%0t got=running expected=finished", $time);
        $fatal(1, "timeout");
    end

endmodule
